// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer.
// Holds funct3/funct7 constants, FSM states and the datapath step mode.
// No logic: used by muldiv_seq and muldiv_step.
package muldiv_seq_pkg;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    localparam logic [2:0] MUL_FUNCT3    = 3'b000;
    localparam logic [2:0] MULH_FUNCT3   = 3'b001;
    localparam logic [2:0] MULHSU_FUNCT3 = 3'b010;
    localparam logic [2:0] MULHU_FUNCT3  = 3'b011;
    localparam logic [2:0] DIV_FUNCT3    = 3'b100;
    localparam logic [2:0] DIVU_FUNCT3   = 3'b101;
    localparam logic [2:0] REM_FUNCT3    = 3'b110;
    localparam logic [2:0] REMU_FUNCT3   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } step_mode_t;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic signed_a(input logic [2:0] f3);
        return (f3 == MULH_FUNCT3) || (f3 == MULHSU_FUNCT3) ||
               (f3 == DIV_FUNCT3)  || (f3 == REM_FUNCT3);
    endfunction

    function automatic logic signed_b(input logic [2:0] f3);
        return (f3 == MULH_FUNCT3) || (f3 == DIV_FUNCT3) || (f3 == REM_FUNCT3);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (shift-add or restoring divide).
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the result is registered.
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  step_mode_t        mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] sub_diff;

    always_comb begin
        // multiply: {hi, multiplier}; add multiplicand on LSB, then shift right with carry
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        // divide: {rem, quot}; trial-subtract from the remainder shifted left by one
        sub_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
        acc_next = '0;
        if (mode == MODE_MUL) begin
            acc_next = {add_sum, acc[XLEN-1:1]};
        end else if (!sub_diff[XLEN]) begin
            acc_next = {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {acc[2*XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer; MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Latency: XLEN+2 cycles (3 for multiply with MULDIV_FAST_MUL_EN), 1 cycle for divide-by-zero/overflow.
// Backpressure: valid_i is only sampled in IDLE; busy_o stalls EX until the done_o cycle.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_f3;
    logic              neg_a;
    logic              neg_b;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;

    logic              accept;
    logic              req_div;
    logic              req_neg_a;
    logic              req_neg_b;
    logic              div_by_zero;
    logic              div_ovf;
    logic              req_special;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   special_res;

    step_mode_t        step_mode;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] acc_calc;
    logic              calc_last;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        accept      = (state == ST_IDLE) && valid_i && !kill_i;
        req_div     = is_div_op(funct3_i);
        req_neg_a   = signed_a(funct3_i) && op_a_i[XLEN-1];
        req_neg_b   = signed_b(funct3_i) && op_b_i[XLEN-1];
        mag_a       = req_neg_a ? -op_a_i : op_a_i;
        mag_b       = req_neg_b ? -op_b_i : op_b_i;
        div_by_zero = req_div && (op_b_i == '0);
        div_ovf     = req_div && signed_b(funct3_i) && (op_a_i == INT_MIN) && (op_b_i == '1);
        req_special = div_by_zero || div_ovf;
        // funct3[1] separates REM/REMU from DIV/DIVU
        if (div_by_zero) begin
            special_res = funct3_i[1] ? op_a_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : INT_MIN;
        end
    end

    assign step_mode = is_div_op(op_f3) ? MODE_DIV : MODE_MUL;

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .mode    (step_mode),
        .acc     (acc),
        .operand (opnd),
        .acc_next(acc_step)
    );

`ifdef MULDIV_FAST_MUL_EN
    // magnitudes are multiplied; FIX applies the sign exactly as for the iterative path
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, acc[XLEN-1:0]} * {{XLEN{1'b0}}, opnd};
    assign acc_calc  = is_div_op(op_f3) ? acc_step : fast_prod;
    assign calc_last = !is_div_op(op_f3) || (cnt == CNT_LAST);
`else
    assign acc_calc  = acc_step;
    assign calc_last = (cnt == CNT_LAST);
`endif

    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        quot_fix = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_f3)
            MUL_FUNCT3:                               fix_res = prod_fix[XLEN-1:0];
            MULH_FUNCT3, MULHSU_FUNCT3, MULHU_FUNCT3: fix_res = prod_fix[2*XLEN-1:XLEN];
            DIV_FUNCT3, DIVU_FUNCT3:                  fix_res = quot_fix;
            default:                                  fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = req_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy_o = 1'b1;
                if (kill_i) begin
                    state_nxt = ST_IDLE;
                end else if (calc_last) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                busy_o    = 1'b1;
                state_nxt = kill_i ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                // a kill here is left to the consumer; the pulse still goes out
                busy_o    = 1'b1;
                done_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            op_f3    <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            acc      <= '0;
            opnd     <= '0;
            result_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_f3 <= funct3_i;
                        neg_a <= req_neg_a;
                        neg_b <= req_neg_b;
                        cnt   <= '0;
                        if (req_div) begin
                            acc  <= {{XLEN{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{XLEN{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                        if (req_special) begin
                            result_o <= special_res;
                        end
                    end
                end
                ST_CALC: begin
                    if (!kill_i) begin
                        acc <= acc_calc;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (!kill_i) begin
                        result_o <= fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M cases, kill/reset aborts and random operands.
// Expected results come from a 64-bit reference model or fixed constants.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif
    localparam int DIV_LAT = XLEN + 2;
    localparam int LAT_MAX = 48;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = '0;

    vec_t plan [16] = '{
        '{MUL_FUNCT3,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{MULH_FUNCT3,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
        '{MULHU_FUNCT3,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{MULHSU_FUNCT3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{DIV_FUNCT3,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
        '{REM_FUNCT3,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
        '{DIVU_FUNCT3,   32'd100,        32'd7,         32'd14},
        '{REMU_FUNCT3,   32'd100,        32'd7,         32'd2},
        '{DIV_FUNCT3,    32'd5,          32'd0,         32'hFFFF_FFFF},
        '{REM_FUNCT3,    32'd5,          32'd0,         32'd5},
        '{DIVU_FUNCT3,   32'd9,          32'd0,         32'hFFFF_FFFF},
        '{REMU_FUNCT3,   32'd9,          32'd0,         32'd9},
        '{DIV_FUNCT3,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
        '{REM_FUNCT3,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
        '{MUL_FUNCT3,    32'd6,          32'd9,         32'd54},
        '{DIV_FUNCT3,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD}
    };

    muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid),
        .funct3_i(funct3),
        .op_a_i  (op_a),
        .op_b_i  (op_b),
        .kill_i  (kill),
        .busy_o  (busy),
        .done_o  (done),
        .result_o(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea_s, eb_s, ea_u, eb_u, p_ss, p_su, p_uu;
        logic signed [31:0] sa, sb;
        logic               ovf;
        ea_s = {{32{a[31]}}, a};
        eb_s = {{32{b[31]}}, b};
        ea_u = {32'd0, a};
        eb_u = {32'd0, b};
        p_ss = ea_s * eb_s;
        p_su = ea_s * eb_u;
        p_uu = ea_u * eb_u;
        sa   = a;
        sb   = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            MUL_FUNCT3:    ref_op = p_ss[31:0];
            MULH_FUNCT3:   ref_op = p_ss[63:32];
            MULHSU_FUNCT3: ref_op = p_su[63:32];
            MULHU_FUNCT3:  ref_op = p_uu[63:32];
            DIV_FUNCT3:    ref_op = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            DIVU_FUNCT3:   ref_op = (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM_FUNCT3:    ref_op = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default:       ref_op = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && ((b == 0) || (((f3 == DIV_FUNCT3) || (f3 == REM_FUNCT3)) &&
                                   (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))))
            return 1;
        return f3[2] ? DIV_LAT : MUL_LAT;
    endfunction

    // scoreboard consumer: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
            else                   chk("result", result, exp_q.pop_front());
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit skip_sync, input bit noise);
        int lat;
        bit busy_ok;
        if (!skip_sync) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        valid  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        exp_q.push_back(exp);
        @(negedge clk);
        valid   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= LAT_MAX; c++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            if (noise) begin
                valid  = 1'($urandom);
                funct3 = 3'($urandom);
                op_a   = $urandom;
                op_b   = $urandom;
            end
            @(negedge clk);
        end
        valid    = 1'b0;
        last_res = exp;
        chk("latency", 32'(lat), 32'(exp_lat(f3, a, b)));
        chk("busy_held", {31'd0, busy_ok}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        valid  = 1'b0;
        kill   = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_result", result,        32'd0);
        rst = 1'b0;

        foreach (plan[i]) run_op(plan[i].f3, plan[i].a, plan[i].b, plan[i].res, 1'b0, 1'b1);

        // kill + valid together in IDLE drops the request
        @(negedge clk);
        valid = 1'b1; kill = 1'b1; funct3 = DIVU_FUNCT3; op_a = 32'd50; op_b = 32'd3;
        @(negedge clk);
        valid = 1'b0; kill = 1'b0;
        chk("kill_idle_busy", {31'd0, busy}, 32'd0);

        // kill at CALC cycle 10, then accept a new request the following cycle
        @(negedge clk);
        valid = 1'b1; funct3 = DIV_FUNCT3; op_a = 32'd1000; op_b = 32'd7;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy",   {31'd0, busy}, 32'd0);
        chk("kill_done",   {31'd0, done}, 32'd0);
        chk("kill_result", result,        last_res);
        run_op(DIVU_FUNCT3, 32'd100, 32'd7, 32'd14, 1'b1, 1'b0);

        // synchronous reset at CALC cycle 5
        @(negedge clk);
        valid = 1'b1; funct3 = MULHU_FUNCT3; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy",   {31'd0, busy}, 32'd0);
        chk("midrst_done",   {31'd0, done}, 32'd0);
        chk("midrst_result", result,        32'd0);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            int          sel;
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = -32'($urandom_range(1, 1000));
                default: ;
            endcase
            run_op(f3, a, b, ref_op(f3, a, b), 1'b0, sel[0]);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits in EX beside the main ALU and is selected when the decoder flags funct7 = 0000001 on an R-type op.
- Accepts one operation, iterates a shared shift/add-subtract datapath once per cycle, then returns a 32-bit result with a one-cycle done pulse.
- Holds the pipeline via busy while iterating.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  request; sampled only in IDLE.
- funct3_i  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  in  XLEN  rs1 value.
- op_b_i  in  XLEN  rs2 value.
- kill_i  in  1  flush from branch/trap; aborts the current operation.
- busy_o  out  1  high from the cycle after acceptance until the done cycle inclusive; EX stall source.
- done_o  out  1  one-cycle pulse; result_o valid.
- result_o  out  XLEN  result; holds its last value otherwise.

Behaviour:
- Reset: state IDLE; busy_o=0, done_o=0, result_o=0; counter=0; all datapath registers cleared.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE + valid_i:
  - Latch funct3 and operands.
  - Record sign flags per op: MULH/DIV/REM use both operands signed; MULHSU uses signed a only; all others unsigned.
  - Convert signed operands to magnitudes.
  - Counter=0; go to CALC.
- IDLE + valid_i + divide/remainder op with op_b_i==0: go straight to DONE.
  - DIV/DIVU result = all ones.
  - REM/REMU result = op_a_i.
- IDLE + valid_i + DIV/REM with op_a_i=0x8000_0000 and op_b_i=0xFFFF_FFFF: go to DONE.
  - DIV result = 0x8000_0000.
  - REM result = 0.
- CALC, one step per cycle, XLEN steps; counter increments each step.
  - Multiply: 2*XLEN-bit product, shift-add on multiplier LSB.
  - Divide: restoring step on a {rem, quot} 2*XLEN-bit register; subtract the divisor from the upper half, keep the difference if non-negative, shift in the quotient bit.
  - When counter==XLEN-1, go to FIX.
- FIX (one cycle): apply the sign correction.
  - Product is negated if the sign flags differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - Select low/high product, quotient or remainder; go to DONE.
- DONE: done_o=1 and result_o valid for exactly this cycle; then IDLE.
- Latency from the acceptance edge to done_o: XLEN+2 cycles on the normal path, 1 cycle on the special-case path.
- valid_i is ignored outside IDLE; the next acceptance is possible in the cycle after DONE, giving back-to-back throughput of one op per XLEN+3 cycles.
- kill_i in CALC or FIX: next state IDLE, no done_o, result_o unchanged, busy_o low next cycle.
- kill_i in DONE: done_o still pulses; the consumer is responsible for discarding it.
- kill_i together with valid_i in IDLE: the request is dropped.
- rst mid-operation: immediate return to the reset values; no done_o.
- funct3 values outside the M set are not possible, since all 8 encodings are defined.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops use a single combinational XLEN×XLEN signed/unsigned multiplier registered in CALC for one cycle.
  - Multiply latency is 3 cycles: CALC, FIX, DONE.
  - Divide ops are unchanged.
- Undefined: multiply uses the iterative shift-add path at XLEN+2 latency; no hardware multiplier is inferred.

Decomposition:
- Defines.v holds the eight funct3 encodings (MUL_FUNCT3 … REMU_FUNCT3), the M-extension funct7 constant and the FSM state encodings.
- Natural sub-module: muldiv_step, the combinational one-iteration datapath.
  - Inputs: mode (mul/div), accumulator, operand.
  - Output: next accumulator.
  - muldiv_seq owns the FSM, counter, sign handling and result muxing.

Test Plan:
- MUL 7 × -3 → done_o after 34 cycles, result 0xFFFF_FFEB; busy_o high for 34 cycles.
- MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000; MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE; MULHSU -1 × 0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV -7 / 2 → 0xFFFF_FFFD; REM -7 / 2 → 0xFFFF_FFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFF_FFFF with done_o in 1 cycle; REM 5 / 0 → 5; DIV 0x8000_0000 / -1 → 0x8000_0000; REM of the same → 0.
- Start DIV, assert kill_i at CALC cycle 10 → no done_o, busy_o low next cycle; a new valid_i is accepted in the following cycle and completes correctly.
- rst at CALC cycle 5 → all outputs 0 next cycle; with MULDIV_FAST_MUL_EN, MUL 6 × 9 → 54 with done_o 3 cycles after acceptance.
